// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter:
// game register map, port widths and the side-write FIFO entry.
package rf_write_arbiter_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] REG_BALL    = 5'd10;
  localparam logic [AW-1:0] REG_LPADDLE = 5'd11;
  localparam logic [AW-1:0] REG_RPADDLE = 5'd12;
  localparam logic [AW-1:0] REG_PLAYER  = 5'd13;
  localparam logic [AW-1:0] REG_GAME    = 5'd14;
  localparam logic [AW-1:0] REG_NOTE1   = 5'd20;
  localparam logic [AW-1:0] REG_NOTE2   = 5'd21;
  localparam logic [AW-1:0] REG_NOTE3   = 5'd22;
  localparam logic [AW-1:0] REG_EXT     = 5'd29;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } side_wr_t;

  // r0 is hardwired, so it is never a legal side target even if lo were 0
  function automatic logic side_addr_ok(input logic [AW-1:0] addr,
                                        input logic [AW-1:0] lo,
                                        input logic [AW-1:0] hi);
    return (addr != '0) && (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/rf_side_fifo.sv
// Side-write FIFO; each entry carries a valid bit that a newer CPU write
// to the same address clears in parallel across all slots.
module rf_side_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clock,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  side_wr_t      i_push_entry,
  input  logic          i_pop,
  input  logic          i_inv_en,
  input  logic [AW-1:0] i_inv_addr,
  output side_wr_t      o_head,
  output logic          o_head_valid,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  side_wr_t         r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_inv_en && (r_mem[i].addr == i_inv_addr)) r_valid[i] <= 1'b0;
      end
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      // A same-cycle push is newer than the CPU write, so it overrides the clear
      if (i_push) begin
        r_mem[r_wr_ptr]   <= i_push_entry;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_head_valid = r_valid[r_rd_ptr];
  assign o_count      = r_count;
  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == FULL_CNT);

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between CPU writeback (priority) and
// side requesters buffered through a FIFO, with a starvation guard.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int DEPTH        = 4,
  parameter int SIDE_LO      = 10,
  parameter int SIDE_HI      = 22,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clock,
  input  logic                         ctrl_reset_n,
  input  logic                         cpu_we,
  input  logic [AW-1:0]                cpu_waddr,
  input  logic [DW-1:0]                cpu_wdata,
  output logic                         cpu_stall,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [AW*N_REQ-1:0]          req_addr,
  input  logic [DW*N_REQ-1:0]          req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         rf_we,
  output logic [AW-1:0]                rf_waddr,
  output logic [DW-1:0]                rf_wdata,
  output logic                         drop_pulse,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW-1:0] RR_LAST    = PW'(N_REQ - 1);
  localparam logic [PW:0]   RR_N       = (PW+1)'(N_REQ);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [AW-1:0] LO_A       = AW'(SIDE_LO);
  localparam logic [AW-1:0] HI_A       = AW'(SIDE_HI);

  logic [PW-1:0] r_rr_ptr;
  logic [SW-1:0] r_starve;
  logic          r_rf_we;
  logic [AW-1:0] r_rf_waddr;
  logic [DW-1:0] r_rf_wdata;
  logic          r_drop;

  logic [AW-1:0]    w_req_addr [N_REQ];
  logic [DW-1:0]    w_req_data [N_REQ];
  logic [N_REQ-1:0] w_grant;
  logic [PW-1:0]    w_gnt_idx;
  logic             w_gnt_any;
  side_wr_t         w_sel;
  logic             w_addr_ok;
  logic             w_push;
  logic             w_cpu_issue;
  logic             w_pop;
  side_wr_t         w_head;
  logic             w_head_valid;
  logic             w_empty;
  logic             w_full;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_req_addr[g] = req_addr[g*AW +: AW];
    assign w_req_data[g] = req_data[g*DW +: DW];
  end

  // Full blocks grants even when a pop frees a slot this cycle; reset gates grants too
  always_comb begin
    logic [PW:0]   v_sum;
    logic [PW-1:0] v_idx;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_sel     = '0;
    v_sum     = '0;
    v_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (v_sum >= RR_N) v_sum = v_sum - RR_N;
      v_idx = v_sum[PW-1:0];
      if (ctrl_reset_n && !w_full && !w_gnt_any && req_valid[v_idx]) begin
        w_gnt_any      = 1'b1;
        w_grant[v_idx] = 1'b1;
        w_gnt_idx      = v_idx;
        w_sel.addr     = w_req_addr[v_idx];
        w_sel.data     = w_req_data[v_idx];
      end
    end
  end

  assign w_addr_ok   = side_addr_ok(w_sel.addr, LO_A, HI_A);
  assign w_push      = w_gnt_any && w_addr_ok;
  assign cpu_stall   = (r_starve == STARVE_MAX);
  assign w_cpu_issue = cpu_we && (cpu_waddr != '0) && !cpu_stall;
  assign w_pop       = !w_cpu_issue && !w_empty;

  rf_side_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clock      (clock),
    .i_rst_n      (ctrl_reset_n),
    .i_push       (w_push),
    .i_push_entry (w_sel),
    .i_pop        (w_pop),
    .i_inv_en     (w_cpu_issue),
    .i_inv_addr   (cpu_waddr),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_count      (fifo_count),
    .o_empty      (w_empty),
    .o_full       (w_full)
  );

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_rr_ptr   <= '0;
      r_starve   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_drop     <= 1'b0;
    end else begin
      if (w_gnt_any) r_rr_ptr <= (w_gnt_idx == RR_LAST) ? '0 : w_gnt_idx + 1'b1;
      // Reaching the limit forces a pop next cycle, so the counter never passes it
      if (w_empty || w_pop) r_starve <= '0;
      else                  r_starve <= r_starve + 1'b1;
      r_drop <= w_gnt_any && !w_addr_ok;
      if (w_cpu_issue) begin
        r_rf_we    <= 1'b1;
        r_rf_waddr <= cpu_waddr;
        r_rf_wdata <= cpu_wdata;
      end else if (w_pop && w_head_valid) begin
        r_rf_we    <= 1'b1;
        r_rf_waddr <= w_head.addr;
        r_rf_wdata <= w_head.data;
      end else begin
        r_rf_we    <= 1'b0;
      end
    end
  end

  assign req_ready  = w_grant;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign drop_pulse = r_drop;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected register-file writes are
// queued as stimulus is driven and matched on the register file's sampling edge.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int N_REQ = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 ctrl_reset_n;
  logic                 cpu_we;
  logic [4:0]           cpu_waddr;
  logic [31:0]          cpu_wdata;
  logic                 cpu_stall;
  logic [N_REQ-1:0]     req_valid;
  logic [5*N_REQ-1:0]   req_addr;
  logic [32*N_REQ-1:0]  req_data;
  logic [N_REQ-1:0]     req_ready;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [31:0]          rf_wdata;
  logic                 drop_pulse;
  logic [2:0]           fifo_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb_q[$];
  exp_t        mon_item;
  logic [31:0] model_rf [32];
  logic [31:0] cpu_d;

  logic [2:0] t3_gnt [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
  logic [2:0] t3_cnt [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [4:0] t4_addr [6] = '{5'd5, 5'd0, 5'd23, 5'd9, REG_NOTE3, REG_BALL};
  logic       t4_drop [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  rf_write_arbiter #(
    .N_REQ(N_REQ), .DEPTH(DEPTH), .SIDE_LO(10), .SIDE_HI(22), .STARVE_LIMIT(8)
  ) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .cpu_we       (cpu_we),
    .cpu_waddr    (cpu_waddr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .drop_pulse   (drop_pulse),
    .fifo_count   (fifo_count)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register file model: stores on the falling edge and checks the scoreboard
  always @(negedge clock) begin
    if (ctrl_reset_n && rf_we) begin
      check_eq("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        mon_item = sb_q.pop_front();
        check_eq("sb_addr", 32'(rf_waddr), 32'(mon_item.addr));
        check_eq("sb_data", rf_wdata, mon_item.data);
      end
      model_rf[rf_waddr] <= rf_wdata;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_we    = 1'b0;
    cpu_waddr = '0;
    cpu_wdata = '0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic drive_req(input int idx, input logic [4:0] a, input logic [31:0] d);
    req_valid[idx]         = 1'b1;
    req_addr[idx*5 +: 5]   = a;
    req_data[idx*32 +: 32] = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    sb_q.push_back('{addr: a, data: d});
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_rf_we"},      32'(rf_we),      32'd0);
    check_eq({tag, "_rf_waddr"},   32'(rf_waddr),   32'd0);
    check_eq({tag, "_rf_wdata"},   rf_wdata,        32'd0);
    check_eq({tag, "_cpu_stall"},  32'(cpu_stall),  32'd0);
    check_eq({tag, "_req_ready"},  32'(req_ready),  32'd0);
    check_eq({tag, "_drop"},       32'(drop_pulse), 32'd0);
    check_eq({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
  endtask

  task automatic sb_done(input string tag);
    check_eq(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    ctrl_reset_n = 1'b0;
    clear_inputs();
    tick();
    ctrl_reset_n = 1'b1;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    check_idle("reset");
    ctrl_reset_n = 1'b1;

    // Single side write drains with cpu idle
    drive_req(1, REG_LPADDLE, 32'h5);
    #1;
    check_eq("t1_ready", 32'(req_ready), 32'b010);
    expect_wr(REG_LPADDLE, 32'h5);
    tick();
    req_valid = '0;
    check_eq("t1_count_push", 32'(fifo_count), 32'd1);
    check_eq("t1_we_early", 32'(rf_we), 32'd0);
    tick();
    check_eq("t1_we", 32'(rf_we), 32'd1);
    check_eq("t1_waddr", 32'(rf_waddr), 32'd11);
    check_eq("t1_wdata", rf_wdata, 32'h5);
    check_eq("t1_count_pop", 32'(fifo_count), 32'd0);
    tick();
    check_eq("t1_we_off", 32'(rf_we), 32'd0);
    sb_done("t1_sb_empty");

    // Starvation guard: cpu busy on r3, one queued side write
    do_reset();
    cpu_d = 32'h1000;
    for (int i = 0; i < 20; i++) begin
      if (i >= 1) check_eq("t2_rf_we_busy", 32'(rf_we), 32'd1);
      if (i == 10) check_eq("t2_side_issue", 32'(rf_waddr), 32'(REG_BALL));
      cpu_we    = 1'b1;
      cpu_waddr = 5'd3;
      cpu_wdata = cpu_d;
      req_valid = '0;
      if (i == 0) drive_req(0, REG_BALL, 32'h10);
      #1;
      if (i == 0) check_eq("t2_ready", 32'(req_ready), 32'b001);
      check_eq("t2_stall", 32'(cpu_stall), 32'(i == 9));
      if (i == 9) begin
        expect_wr(REG_BALL, 32'h10);
      end else begin
        expect_wr(5'd3, cpu_d);
        cpu_d = cpu_d + 32'd1;
      end
      tick();
    end
    cpu_we = 1'b0;
    check_eq("t2_last_we", 32'(rf_we), 32'd1);
    check_eq("t2_last_addr", 32'(rf_waddr), 32'd3);
    tick();
    tick();
    sb_done("t2_sb_empty");

    // Round-robin fill with cpu busy, then full blocks grants during a pop
    do_reset();
    cpu_we    = 1'b1;
    cpu_waddr = 5'd3;
    cpu_wdata = 32'h300;
    drive_req(0, REG_LPADDLE, 32'h100);
    drive_req(1, REG_RPADDLE, 32'h101);
    drive_req(2, REG_PLAYER,  32'h102);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t3_grant", 32'(req_ready), 32'(t3_gnt[i]));
      check_eq("t3_count", 32'(fifo_count), 32'(t3_cnt[i]));
      expect_wr(5'd3, 32'h300);
      tick();
    end
    cpu_we = 1'b0;
    #1;
    check_eq("t3_full_pop_ready", 32'(req_ready), 32'd0);
    check_eq("t3_full_count", 32'(fifo_count), 32'd4);
    expect_wr(REG_LPADDLE, 32'h100);
    expect_wr(REG_RPADDLE, 32'h101);
    expect_wr(REG_PLAYER,  32'h102);
    expect_wr(REG_LPADDLE, 32'h100);
    tick();
    req_valid = '0;
    check_eq("t3_count_after_pop", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 5; i++) tick();
    check_eq("t3_drained", 32'(fifo_count), 32'd0);
    sb_done("t3_sb_empty");

    // Address filter on requester 2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_req(2, t4_addr[i], 32'h400 + 32'(i));
      #1;
      check_eq("t4_ready", 32'(req_ready), 32'b100);
      if (!t4_drop[i]) expect_wr(t4_addr[i], 32'h400 + 32'(i));
      tick();
      req_valid = '0;
      check_eq("t4_drop", 32'(drop_pulse), 32'(t4_drop[i]));
      check_eq("t4_count", 32'(fifo_count), 32'(!t4_drop[i]));
      tick();
      check_eq("t4_drop_clear", 32'(drop_pulse), 32'd0);
      check_eq("t4_rf_we", 32'(rf_we), 32'(!t4_drop[i]));
      tick();
    end
    sb_done("t4_sb_empty");

    // Coherence: newer cpu write invalidates queued entry; same-cycle push stays valid
    do_reset();
    drive_req(0, REG_NOTE1, 32'hA);
    tick();
    req_valid = '0;
    cpu_we    = 1'b1;
    cpu_waddr = REG_NOTE1;
    cpu_wdata = 32'hB;
    expect_wr(REG_NOTE1, 32'hB);
    tick();
    cpu_waddr = 5'd0;
    cpu_wdata = 32'hDEAD;
    check_eq("t5_cpu_we", 32'(rf_we), 32'd1);
    check_eq("t5_cpu_data", rf_wdata, 32'hB);
    check_eq("t5_count_held", 32'(fifo_count), 32'd1);
    tick();
    check_eq("t5_invalid_pop_we", 32'(rf_we), 32'd0);
    check_eq("t5_invalid_pop_count", 32'(fifo_count), 32'd0);
    cpu_waddr = REG_NOTE2;
    cpu_wdata = 32'hC;
    drive_req(0, REG_NOTE2, 32'hD);
    expect_wr(REG_NOTE2, 32'hC);
    expect_wr(REG_NOTE2, 32'hD);
    tick();
    cpu_we    = 1'b0;
    req_valid = '0;
    check_eq("t5_same_cycle_count", 32'(fifo_count), 32'd1);
    tick();
    check_eq("t5_same_cycle_we", 32'(rf_we), 32'd1);
    check_eq("t5_same_cycle_data", rf_wdata, 32'hD);
    tick();
    check_eq("t5_reg20", model_rf[20], 32'hB);
    check_eq("t5_reg21", model_rf[21], 32'hD);
    sb_done("t5_sb_empty");

    // Asynchronous reset mid-cycle with entries queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cpu_we    = 1'b1;
      cpu_waddr = 5'd3;
      cpu_wdata = 32'h600 + 32'(i);
      drive_req(0, REG_BALL + 5'(i), 32'h60 + 32'(i));
      if (i < 2) expect_wr(5'd3, 32'h600 + 32'(i));
      tick();
    end
    cpu_we    = 1'b0;
    req_valid = '0;
    #1;
    check_eq("t6_count_before", 32'(fifo_count), 32'd3);
    check_eq("t6_we_before", 32'(rf_we), 32'd1);
    #1;
    ctrl_reset_n = 1'b0;
    #1;
    check_idle("t6_async");
    tick();
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t6_no_stray_we", 32'(rf_we), 32'd0);
      check_eq("t6_empty", 32'(fifo_count), 32'd0);
    end
    sb_done("t6_sb_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
